// File: rtl/key_debounce_bank_pkg.sv
// Shared types and constants for the key debounce bank.
// FSM state encoding, synchroniser depth and default debounce length.
package key_debounce_bank_pkg;

  typedef enum logic [1:0] {
    ST_REL        = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_REL_WAIT   = 2'd3
  } kdb_state_e;

  localparam int SYNC_DEPTH       = 2;
  localparam int DEF_DEBOUNCE_CYC = 230000;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: synchroniser, debounce FSM,
// saturating stability counter and registered edge pulses.
module key_debounce_ch
  import key_debounce_bank_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int   CNT_W        = 18,
  parameter logic ACT_LOW      = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_rise,
  output logic key_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  synced;
  kdb_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;

  assign synced = sync_q[SYNC_DEPTH-1] ^ ACT_LOW;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], key_raw};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_REL;
      cnt_q     <= '0;
      key_level <= 1'b0;
      key_rise  <= 1'b0;
      key_fall  <= 1'b0;
    end else begin
      key_rise <= 1'b0;
      key_fall <= 1'b0;
      unique case (state_q)
        ST_REL: begin
          cnt_q <= '0;
          if (synced) state_q <= ST_PRESS_WAIT;
        end
        ST_PRESS_WAIT: begin
          if (!synced) begin
            state_q <= ST_REL;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_PRESSED;
            cnt_q     <= '0;
            key_level <= 1'b1;
            key_rise  <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          cnt_q <= '0;
          if (!synced) state_q <= ST_REL_WAIT;
        end
        ST_REL_WAIT: begin
          // a bounce back high returns to PRESSED silently
          if (synced) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_REL;
            cnt_q     <= '0;
            key_level <= 1'b0;
            key_fall  <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_REL;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of debounced keys with sticky press flags and a
// CPU read port that can clear the flags it returns.
module key_debounce_bank
  import key_debounce_bank_pkg::*;
#(
  parameter int              N_CH         = 4,
  parameter int              DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int              CNT_W        = 18,
  parameter logic [N_CH-1:0] ACT_LOW_MASK = '0,
  parameter bit              CLR_ON_READ  = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N_CH-1:0] keys_in,
  input  logic            rd_en,
  input  logic            clr_en,
  input  logic [N_CH-1:0] clr_mask,
  output logic [N_CH-1:0] key_level,
  output logic [N_CH-1:0] key_rise,
  output logic [N_CH-1:0] key_fall,
  output logic [N_CH-1:0] pending,
  output logic [15:0]     rd_data
);

  if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYC)) begin : g_cnt_w_bad
    $error("CNT_W too small for DEBOUNCE_CYC");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_n_ch_bad
    $error("N_CH must be 1..16");
  end
  if (DEBOUNCE_CYC < 2) begin : g_deb_bad
    $error("DEBOUNCE_CYC must be >= 2");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W),
      .ACT_LOW      (ACT_LOW_MASK[i])
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .key_raw   (keys_in[i]),
      .key_level (key_level[i]),
      .key_rise  (key_rise[i]),
      .key_fall  (key_fall[i])
    );
  end

  logic [N_CH-1:0] clr_bits;

  always_comb begin
    clr_bits = '0;
    if (clr_en) clr_bits = clr_bits | clr_mask;
    if (CLR_ON_READ && rd_en) clr_bits = clr_bits | pending;
  end

  // set is OR-ed last so a same-cycle clear never drops an event
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      rd_data <= '0;
    end else begin
      pending <= (pending & ~clr_bits) | key_rise;
      if (rd_en) rd_data <= 16'(pending);
    end
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Self-checking bench: run-length debounce model plus
// directed scenarios with hand-computed expectations.
module tb_key_debounce_bank;

  localparam int         N   = 4;
  localparam int         DEB = 8;
  localparam logic [3:0] ALM = 4'b1000;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [N-1:0] keys_in;
  logic         rd_en;
  logic         clr_en;
  logic [N-1:0] clr_mask;
  logic [N-1:0] key_level, key_rise, key_fall, pending;
  logic [15:0]  rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  int rise1_cnt = 0;

  always #5 clock = ~clock;

  key_debounce_bank #(
    .N_CH         (N),
    .DEBOUNCE_CYC (DEB),
    .CNT_W        (4),
    .ACT_LOW_MASK (ALM),
    .CLR_ON_READ  (1'b1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .keys_in   (keys_in),
    .rd_en     (rd_en),
    .clr_en    (clr_en),
    .clr_mask  (clr_mask),
    .key_level (key_level),
    .key_rise  (key_rise),
    .key_fall  (key_fall),
    .pending   (pending),
    .rd_data   (rd_data)
  );

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a level is accepted once the synchronised input has
  // disagreed with it on DEB+1 consecutive clock edges.
  logic [N-1:0] m_raw1, m_raw2, m_level, m_rise, m_fall, m_pend;
  logic [15:0]  m_rd;
  int           m_run [N];

  always @(posedge clock or negedge reset_n) begin : model
    logic [N-1:0] syn, nrise, nfall, clr;
    if (!reset_n) begin
      m_raw1 = '0; m_raw2 = '0; m_level = '0;
      m_rise = '0; m_fall = '0; m_pend = '0; m_rd = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      syn = m_raw2 ^ ALM;
      nrise = '0;
      nfall = '0;
      for (int i = 0; i < N; i++) begin
        if (syn[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_level[i] = syn[i];
            if (syn[i]) nrise[i] = 1'b1;
            else nfall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      clr = (clr_en ? clr_mask : '0) | (rd_en ? m_pend : '0);
      if (rd_en) m_rd = 16'(m_pend);
      m_pend = (m_pend & ~clr) | m_rise;
      m_rise = nrise;
      m_fall = nfall;
      m_raw2 = m_raw1;
      m_raw1 = keys_in;
    end
  end

  always @(negedge clock) begin
    chk("key_level", 16'(key_level), 16'(m_level));
    chk("key_rise",  16'(key_rise),  16'(m_rise));
    chk("key_fall",  16'(key_fall),  16'(m_fall));
    chk("pending",   16'(pending),   16'(m_pend));
    chk("rd_data",   rd_data,        m_rd);
    if (key_rise[1]) rise1_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    keys_in  = 4'b1000;
    rd_en    = 1'b0;
    clr_en   = 1'b0;
    clr_mask = '0;
    tick(3);
    chk("rst_level", 16'(key_level), 16'h0);
    chk("rst_pend",  16'(pending),   16'h0);
    chk("rst_rd",    rd_data,        16'h0);
    reset_n = 1'b1;
    tick(5);

    // ch0 press: pulse exactly 11 cycles after the edge
    keys_in[0] = 1'b1;
    tick(10);
    chk("ch0_rise_early", 16'(key_rise), 16'h0);
    tick(1);
    chk("ch0_rise", 16'(key_rise), 16'h1);
    tick(1);
    chk("ch0_rise_end", 16'(key_rise), 16'h0);
    tick(8);
    chk("ch0_level", 16'(key_level), 16'h1);
    chk("ch0_pend",  16'(pending),   16'h1);

    // ch1 bounce every 3 cycles never qualifies
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) keys_in[1] = ~keys_in[1];
      tick(1);
    end
    keys_in[1] = 1'b0;
    tick(12);
    chk("ch1_no_rise", 16'(rise1_cnt), 16'h0);
    chk("ch1_level",   16'(key_level[1]), 16'h0);

    // pending 0101 then clear-on-read
    keys_in[2] = 1'b1;
    tick(12);
    chk("pend_0101", 16'(pending), 16'h5);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("rd_0005",   rd_data,        16'h0005);
    chk("rd_clears", 16'(pending),   16'h0);

    // set wins over a same-cycle clear
    keys_in[2] = 1'b0;
    tick(14);
    keys_in[2] = 1'b1;
    tick(11);
    chk("ch2_rise", 16'(key_rise), 16'h4);
    clr_en   = 1'b1;
    clr_mask = 4'b0100;
    tick(1);
    clr_en = 1'b0;
    chk("set_wins", 16'(pending), 16'h4);
    clr_en = 1'b1;
    tick(1);
    clr_en = 1'b0;
    chk("clr_mask", 16'(pending), 16'h0);
    keys_in[2] = 1'b0;
    tick(14);

    // active-low channel 3
    keys_in[3] = 1'b0;
    tick(11);
    chk("ch3_rise", 16'(key_rise), 16'h8);
    tick(5);
    keys_in[3] = 1'b1;
    tick(11);
    chk("ch3_fall", 16'(key_fall), 16'h8);
    tick(3);

    // reset mid-debounce discards the count
    keys_in[0] = 1'b0;
    tick(14);
    keys_in[0] = 1'b1;
    tick(8);
    reset_n = 1'b0;
    tick(1);
    chk("mid_rst_rise",  16'(key_rise),  16'h0);
    chk("mid_rst_level", 16'(key_level), 16'h0);
    chk("mid_rst_pend",  16'(pending),   16'h0);
    tick(1);
    reset_n = 1'b1;
    tick(10);
    chk("post_rst_early", 16'(key_rise), 16'h0);
    tick(1);
    chk("post_rst_rise", 16'(key_rise), 16'h1);
    tick(1);
    chk("post_rst_once", 16'(key_rise), 16'h0);
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
